rr_decoder_arbiter: RTL and testbench



---
 rtl/rr_decoder_arbiter.sv | 102 ++++++++++
 tb/tb_rr_decoder_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
// 16-way round-robin arbiter with a bounded hold time and one dead cycle between grants.
// The winner is kept as a 4-bit index and decoded to a registered one-hot grant.
module rr_decoder_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        En,
    input  logic [0:15] req,
    output logic [0:15] gnt,
    output logic [3:0]  gnt_idx,
    output logic        gnt_valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [0:15]      gnt_q, gnt_d;
    logic             valid_q, valid_d;

    logic             found;
    logic [3:0]       winner;
    logic [3:0]       cand;
    logic             release_now;

    // Search starts at ptr and wraps; the 4-bit add gives the mod-16 wrap for free.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        cand   = '0;
        for (int k = 0; k < 16; k++) begin
            cand = ptr_q + 4'(k);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign release_now = !req[idx_q] || !En || (hold_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        valid_d = 1'b0;
        gnt_d   = '0;

        case (state_q)
            IDLE: begin
                if (En && found) begin
                    state_d = GRANT;
                    idx_d   = winner;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                // Releasing always passes through IDLE, which is the dead cycle.
                if (release_now) begin
                    state_d = IDLE;
                    ptr_d   = idx_q + 4'd1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == GRANT);
        gnt_d[idx_d] = valid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Bench for rr_decoder_arbiter: directed table, hand-written corner sequences and
// random traffic compared against a queue/modulo-arithmetic reference model.
module tb_rr_decoder_arbiter;

    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_a, en_b;
    logic [0:15] req_a, req_b;
    logic [0:15] gnt_a, gnt_b;
    logic [3:0]  idx_a, idx_b;
    logic        valid_a, valid_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_decoder_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .En(en_a), .req(req_a),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(valid_a)
    );

    rr_decoder_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .En(en_b), .req(req_b),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(valid_b)
    );

    // Reference model: owner is -1 when nobody holds the resource, held counts granted cycles.
    int m_owner, m_held, m_ptr, m_last;

    function automatic logic [0:15] onehot(input int i);
        logic [0:15] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_last  = 0;
    endfunction

    function automatic void model_step(input logic e, input logic [0:15] r);
        if (m_owner >= 0) begin
            if (!r[m_owner] || !e || m_held == MAX_HOLD) begin
                m_ptr   = (m_owner + 1) % 16;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end else if (e && r != '0) begin
            for (int k = 0; k < 16; k++) begin
                int i;
                i = (m_ptr + k) % 16;
                if (r[i]) begin
                    m_owner = i;
                    m_held  = 1;
                    m_last  = i;
                    break;
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [0:15] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check({tag, ".gnt"},   32'(gnt_a),   32'(eg));
        check({tag, ".idx"},   32'(idx_a),   32'(m_last));
        check({tag, ".valid"}, 32'(valid_a), 32'(m_owner >= 0));
    endtask

    task automatic step_a(input logic e, input logic [0:15] r, input string tag);
        en_a  = e;
        req_a = r;
        @(posedge clk);
        #1;
        model_step(e, r);
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset.gnt",   32'(gnt_a),   32'd0);
        check("reset.idx",   32'(idx_a),   32'd0);
        check("reset.valid", 32'(valid_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        en;
        logic [0:15] req;
        logic        exp_valid;
        logic [3:0]  exp_idx;
    } vec_t;

    vec_t        tbl[7];
    logic [3:0]  exp_q[$];
    logic [3:0]  got_q[$];
    int          len_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:15] r;
        logic        prev_v;
        int          run;
        int          cnt[16];

        reset = 1'b1;
        en_a = 1'b0; req_a = '0;
        en_b = 1'b0; req_b = '0;
        model_reset();

        // Single requester 5 held three cycles, then a 5|6 request shows ptr moved to 6.
        tbl[0] = '{1'b1, onehot(5), 1'b1, 4'd5};
        tbl[1] = '{1'b1, onehot(5), 1'b1, 4'd5};
        tbl[2] = '{1'b1, onehot(5), 1'b1, 4'd5};
        tbl[3] = '{1'b1, '0,        1'b0, 4'd5};
        tbl[4] = '{1'b1, '0,        1'b0, 4'd5};
        tbl[5] = '{1'b1, onehot(5) | onehot(6), 1'b1, 4'd6};
        tbl[6] = '{1'b1, '0,        1'b0, 4'd6};

        // Test 1: idle with enable and no requests.
        do_reset();
        for (int c = 0; c < 10; c++) step_a(1'b1, '0, "idle");

        // Test 2: table-driven.
        for (int v = 0; v < 7; v++) begin
            logic [0:15] eg;
            step_a(tbl[v].en, tbl[v].req, "tbl");
            eg = '0;
            if (tbl[v].exp_valid) eg[tbl[v].exp_idx] = 1'b1;
            check("tbl.valid", 32'(valid_a), 32'(tbl[v].exp_valid));
            check("tbl.idx",   32'(idx_a),   32'(tbl[v].exp_idx));
            check("tbl.gnt",   32'(gnt_a),   32'(eg));
        end

        // Test 3: requesters 0, 3, 15 held continuously; expiry-driven rotation with wrap.
        do_reset();
        r = onehot(0) | onehot(3) | onehot(15);
        exp_q = '{4'd0, 4'd3, 4'd15, 4'd0};
        got_q.delete();
        len_q.delete();
        prev_v = 1'b0;
        run = 0;
        for (int c = 0; c < 40; c++) begin
            step_a(1'b1, r, "rot");
            if (valid_a && !prev_v) got_q.push_back(idx_a);
            if (valid_a) run++;
            if (!valid_a && prev_v) begin
                len_q.push_back(run);
                run = 0;
            end
            prev_v = valid_a;
        end
        check("rot.count", 32'(got_q.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("rot.order", 32'(got_q[i]), 32'(exp_q[i]));
        check("rot.lens", 32'(len_q.size() >= 4), 32'd1);
        for (int i = 0; i < len_q.size(); i++) check("rot.len", 32'(len_q[i]), MAX_HOLD);

        // Test 4: En pulse low mid-grant releases and moves ptr past 7.
        do_reset();
        for (int c = 0; c < 3; c++) step_a(1'b1, onehot(7), "en.hold");
        step_a(1'b0, onehot(7) | onehot(9), "en.drop");
        check("en.drop.valid", 32'(valid_a), 32'd0);
        step_a(1'b1, onehot(7) | onehot(9), "en.back");
        check("en.back.idx",   32'(idx_a),   32'd9);
        check("en.back.valid", 32'(valid_a), 32'd1);

        // Test 5: asynchronous reset in the middle of a grant to 12.
        do_reset();
        step_a(1'b1, onehot(12), "ar.grant");
        step_a(1'b1, onehot(12), "ar.grant");
        #2;
        reset = 1'b1;
        #1;
        check("ar.gnt",   32'(gnt_a),   32'd0);
        check("ar.idx",   32'(idx_a),   32'd0);
        check("ar.valid", 32'(valid_a), 32'd0);
        #2;
        reset = 1'b0;
        model_reset();
        step_a(1'b1, onehot(12), "ar.regrant");
        check("ar.regrant.idx", 32'(idx_a), 32'd12);

        // Random traffic, with sticky requests so hold expiry is reached.
        do_reset();
        r = '0;
        for (int c = 0; c < 400; c++) begin
            logic e;
            e = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) r = 16'($urandom) & 16'($urandom);
            step_a(e, r, "rand");
        end

        // Test 6: MAX_HOLD=1 instance with every request high.
        en_b  = 1'b1;
        req_b = '1;
        do_reset();
        for (int i = 0; i < 16; i++) cnt[i] = 0;
        for (int c = 0; c < 32; c++) begin
            logic [0:15] eg;
            @(posedge clk);
            #1;
            eg = '0;
            if (c % 2 == 0) eg[c / 2] = 1'b1;
            check("mh1.valid", 32'(valid_b), 32'(c % 2 == 0));
            check("mh1.gnt",   32'(gnt_b),   32'(eg));
            if (c % 2 == 0) check("mh1.idx", 32'(idx_b), 32'(c / 2));
            if (valid_b) cnt[idx_b]++;
        end
        for (int i = 0; i < 16; i++) check("mh1.once", 32'(cnt[i]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
